// File: rtl/mul_pkg.sv
// Shared encodings for the multiplier issue controller: op codes, muler sign modes, FSM states.
// Pure definitions; no logic or timing of its own.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULH   = 2'd1;
    localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mul_state_e;

    function automatic logic [1:0] op_to_sgn(input logic [1:0] op);
        case (op)
            MUL_OP_MULHSU: op_to_sgn = SGN_SU;
            MUL_OP_MULHU:  op_to_sgn = SGN_UU;
            default:       op_to_sgn = SGN_SS;
        endcase
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of the issue-side, muler-side and response-side handshakes of mul_issue_ctrl.
// master = the controller, slave = its environment (issue stage, muler, writeback).
interface mul_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        flush;

    logic        mul_in_valid;
    logic        mul_flush;
    logic        mul_mulw;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand;
    logic [63:0] mul_multiplier;
    logic        mul_out_ready;
    logic        mul_out_valid;
    logic [63:0] mul_result_hi;
    logic [63:0] mul_result_lo;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;

    modport master (
        input  req_valid, req_op, req_word, req_src1, req_src2, flush,
        input  mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        input  resp_ready,
        output req_ready, mul_in_valid, mul_flush, mul_mulw, mul_signed,
        output mul_multiplicand, mul_multiplier,
        output resp_valid, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_op, req_word, req_src1, req_src2, flush,
        output mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        output resp_ready,
        input  req_ready, mul_in_valid, mul_flush, mul_mulw, mul_signed,
        input  mul_multiplicand, mul_multiplier,
        input  resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/mul_result_sel.sv
// Picks the architectural result from a 128-bit product: lo for MUL, hi for MULH*,
// sign-extended low word for MULW. Purely combinational, no backpressure.
module mul_result_sel
    import mul_pkg::*;
(
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] hi,
    input  logic [63:0] lo,
    output logic [63:0] result
);

    always_comb begin
        result = hi;
        if (op == MUL_OP_MUL) begin
            // word only means anything for MUL; the high-half ops ignore it
            result = word ? {{32{lo[31]}}, lo[31:0]} : lo;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Requester side of the muler handshake: issues one op, waits (with timeout), holds result until taken.
// Latency 1 + muler + 1 cycles; one op in flight, req_ready low outside IDLE. Optional MULCTL_RESULT_REUSE_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int WAIT_MAX = 63
) (
    input  logic             clock,
    input  logic             reset,
    mul_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    mul_state_e  state_q, state_d;
    logic [1:0]  op_q, sgn_q;
    logic        mulw_q;
    logic [63:0] src1_q, src2_q, data_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic        accept, timeout, hit;
    logic [1:0]  sel_op;
    logic        sel_word;
    logic [63:0] sel_hi, sel_lo, sel_res;

    assign accept  = bus.req_valid & bus.req_ready;
    // a result landing on the last allowed cycle still counts as a normal completion
    assign timeout = (state_q == WAIT) & (cnt_q == CW'(WAIT_MAX)) & ~bus.mul_out_valid;

`ifdef MULCTL_RESULT_REUSE_EN
    logic        c_vld;
    logic [63:0] c_hi, c_lo, c_src1, c_src2;
    logic [1:0]  c_sgn;

    assign hit = c_vld & ~(bus.req_word & (bus.req_op == MUL_OP_MUL))
               & (bus.req_src1 == c_src1) & (bus.req_src2 == c_src2)
               & (op_to_sgn(bus.req_op) == c_sgn);

    always_comb begin
        sel_op   = op_q;
        sel_word = mulw_q;
        sel_hi   = bus.mul_result_hi;
        sel_lo   = bus.mul_result_lo;
        if (state_q == IDLE) begin
            sel_op   = bus.req_op;
            sel_word = 1'b0;
            sel_hi   = c_hi;
            sel_lo   = c_lo;
        end
    end

    // only full 64x64 products that actually completed are worth remembering
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_vld  <= 1'b0;
            c_hi   <= '0;
            c_lo   <= '0;
            c_src1 <= '0;
            c_src2 <= '0;
            c_sgn  <= '0;
        end else if ((state_q == WAIT) && !bus.flush && bus.mul_out_valid && !mulw_q) begin
            c_vld  <= 1'b1;
            c_hi   <= bus.mul_result_hi;
            c_lo   <= bus.mul_result_lo;
            c_src1 <= src1_q;
            c_src2 <= src2_q;
            c_sgn  <= sgn_q;
        end
    end
`else
    assign hit = 1'b0;

    always_comb begin
        sel_op   = op_q;
        sel_word = mulw_q;
        sel_hi   = bus.mul_result_hi;
        sel_lo   = bus.mul_result_lo;
    end
`endif

    mul_result_sel u_sel (
        .op     (sel_op),
        .word   (sel_word),
        .hi     (sel_hi),
        .lo     (sel_lo),
        .result (sel_res)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = hit ? DONE : ISSUE;
            ISSUE:   if (bus.flush) state_d = IDLE;
                     else if (bus.mul_out_ready) state_d = WAIT;
            WAIT:    if (bus.flush) state_d = IDLE;
                     else if (bus.mul_out_valid || timeout) state_d = DONE;
            DONE:    if (bus.flush || bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready        = (state_q == IDLE) & ~bus.flush;
        bus.mul_in_valid     = (state_q == ISSUE);
        bus.mul_flush        = (((state_q == ISSUE) | (state_q == WAIT)) & bus.flush) | timeout;
        bus.mul_mulw         = mulw_q;
        bus.mul_signed       = sgn_q;
        bus.mul_multiplicand = src1_q;
        bus.mul_multiplier   = src2_q;
        bus.resp_valid       = (state_q == DONE);
        bus.resp_data        = data_q;
        bus.resp_err         = err_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            sgn_q  <= '0;
            mulw_q <= 1'b0;
            src1_q <= '0;
            src2_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
            case (state_q)
                IDLE: if (accept) begin
                    op_q   <= bus.req_op;
                    sgn_q  <= op_to_sgn(bus.req_op);
                    mulw_q <= bus.req_word & (bus.req_op == MUL_OP_MUL);
                    src1_q <= bus.req_src1;
                    src2_q <= bus.req_src2;
                    err_q  <= 1'b0;
                    if (hit) data_q <= sel_res;
                end
                WAIT: if (!bus.flush) begin
                    if (bus.mul_out_valid) begin
                        data_q <= sel_res;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural muler stub (latency, ready delay, mute, stray pulse).
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(.WAIT_MAX(63)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // stub controls (written by the main sequence) and monitor counters (written by the stub)
    bit   stub_mute  = 1'b0;
    int   stub_lat   = 2;
    int   rdy_delay  = 0;
    int   stray_tok  = 0;
    int   stray_seen = 0;
    int   iv_run = 0, iv_total = 0, flush_cnt = 0, rv_cnt = 0, lat_cnt = 0;
    bit   lat_active = 1'b0;
    logic [1:0] last_sgn  = 2'b0;
    logic       last_mulw = 1'b0;

    initial begin : muler_stub
        logic [63:0]  sa, sb;
        logic [1:0]   ssgn;
        logic         sw, acc, flsh;
        logic [127:0] ea, eb, prod;
        int           scnt;
        scnt = 0;
        prod = '0;
        bus.mul_out_valid = 1'b0;
        bus.mul_out_ready = 1'b0;
        bus.mul_result_hi = '0;
        bus.mul_result_lo = '0;
        forever begin
            @(negedge clock);
            if (bus.mul_in_valid) begin
                iv_run++;
                iv_total++;
                last_sgn  = bus.mul_signed;
                last_mulw = bus.mul_mulw;
            end else begin
                iv_run = 0;
            end
            if (bus.mul_flush) flush_cnt++;
            if (bus.resp_valid) begin
                rv_cnt++;
                lat_active = 1'b0;
            end else if (lat_active) begin
                lat_cnt++;
            end
            acc  = bus.mul_in_valid && bus.mul_out_ready;
            flsh = bus.mul_flush;
            sa   = bus.mul_multiplicand;
            sb   = bus.mul_multiplier;
            ssgn = bus.mul_signed;
            sw   = bus.mul_mulw;
            if (acc) begin
                lat_cnt    = 0;
                lat_active = 1'b1;
            end
            @(posedge clock);
            #1;
            bus.mul_out_valid = 1'b0;
            bus.mul_result_hi = '0;
            bus.mul_result_lo = '0;
            if (flsh) scnt = 0;
            if (acc && !stub_mute) begin
                if (sw) begin
                    ea = {{96{sa[31]}}, sa[31:0]};
                    eb = {{96{sb[31]}}, sb[31:0]};
                end else begin
                    ea = {{64{ssgn[1] & sa[63]}}, sa};
                    eb = {{64{ssgn[0] & sb[63]}}, sb};
                end
                prod = ea * eb;
                scnt = stub_lat;
            end
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    bus.mul_out_valid = 1'b1;
                    bus.mul_result_hi = prod[127:64];
                    bus.mul_result_lo = prod[63:0];
                end
            end
            if (stray_tok != stray_seen) begin
                stray_seen        = stray_tok;
                bus.mul_out_valid = 1'b1;
                bus.mul_result_hi = 64'hDEAD_BEEF_0000_0001;
                bus.mul_result_lo = 64'h0000_0000_1234_5678;
            end
            bus.mul_out_ready = (iv_run >= rdy_delay);
        end
    end

    task automatic issue_only(input logic [1:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
        bit got;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_word  = w;
        bus.req_src1  = s1;
        bus.req_src2  = s2;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", 64'(got), 64'd1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic release_resp();
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2,
                          input bit rel, output logic [63:0] d, output logic e);
        bit got;
        issue_only(op, w, s1, s2);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("resp_seen", 64'(got), 64'd1);
        d = bus.resp_data;
        e = bus.resp_err;
        if (rel) release_resp();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [63:0] d;
        logic        e;
        int          base, fbase, rbase;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_word   = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_req_ready",  64'(bus.req_ready),        64'd1);
        chk("rst_in_valid",   64'(bus.mul_in_valid),     64'd0);
        chk("rst_mul_flush",  64'(bus.mul_flush),        64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid),       64'd0);
        chk("rst_resp_err",   64'(bus.resp_err),         64'd0);
        chk("rst_resp_data",  bus.resp_data,             64'd0);
        chk("rst_signed",     64'(bus.mul_signed),       64'd0);
        chk("rst_mcand",      bus.mul_multiplicand,      64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // MUL with muler holding off ready for two cycles
        rdy_delay = 2;
        base = iv_total;
        run_op(MUL_OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, d, e);
        chk("mul_data",    d,                   64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul_err",     64'(e),              64'd0);
        chk("mul_sgn",     64'(last_sgn),       64'(2'b11));
        chk("mul_iv_cyc",  64'(iv_total - base), 64'd3);
        chk("mul_lat",     64'(lat_cnt),        64'd2);
        rdy_delay = 0;

        run_op(MUL_OP_MULHU, 1'b0, '1, '1, 1'b1, d, e);
        chk("mulhu_data",  d,             64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulhu_sgn",   64'(last_sgn), 64'(2'b00));
        run_op(MUL_OP_MULH, 1'b0, '1, '1, 1'b1, d, e);
        chk("mulh_data",   d,             64'd0);
        chk("mulh_sgn",    64'(last_sgn), 64'(2'b11));
        run_op(MUL_OP_MULHSU, 1'b0, '1, '1, 1'b1, d, e);
        chk("mulhsu_data", d,             64'hFFFF_FFFF_FFFF_FFFF);
        chk("mulhsu_sgn",  64'(last_sgn), 64'(2'b10));

        run_op(MUL_OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b1, d, e);
        chk("mulw_data",   d,              64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulw_flag",   64'(last_mulw), 64'd1);
        run_op(MUL_OP_MULHU, 1'b1, '1, '1, 1'b1, d, e);
        chk("hu_word_data", d,              64'hFFFF_FFFF_FFFF_FFFE);
        chk("hu_word_flag", 64'(last_mulw), 64'd0);

        // flush together with a request: nothing accepted
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = MUL_OP_MUL;
        bus.flush     = 1'b1;
        @(negedge clock);
        chk("flush_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        base = iv_total;
        repeat (3) @(negedge clock);
        chk("flush_req_noissue", 64'(iv_total - base), 64'd0);

        // flush five cycles into WAIT, then a stray result pulse
        stub_mute = 1'b1;
        fbase = flush_cnt;
        rbase = rv_cnt;
        issue_only(MUL_OP_MUL, 1'b0, 64'd9, 64'd9);
        repeat (6) @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        repeat (4) @(negedge clock);
        chk("wflush_pulses", 64'(flush_cnt - fbase), 64'd1);
        chk("wflush_noresp", 64'(rv_cnt - rbase),    64'd0);
        chk("wflush_idle",   64'(bus.req_ready),     64'd1);
        stray_tok++;
        repeat (4) @(negedge clock);
        chk("stray_noresp",  64'(rv_cnt - rbase),    64'd0);
        chk("stray_idle",    64'(bus.req_ready),     64'd1);
        stub_mute = 1'b0;
        run_op(MUL_OP_MUL, 1'b0, 64'd4, 64'd5, 1'b1, d, e);
        chk("after_flush_data", d, 64'd20);

        // downstream stalls for six cycles
        run_op(MUL_OP_MUL, 1'b0, 64'd6, 64'd7, 1'b0, d, e);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("hold_data",      bus.resp_data,         64'd42);
            chk("hold_valid",     64'(bus.resp_valid),   64'd1);
            chk("hold_req_ready", 64'(bus.req_ready),    64'd0);
        end
        release_resp();

        // flush while the response is waiting
        run_op(MUL_OP_MUL, 1'b0, 64'd2, 64'd3, 1'b0, d, e);
        chk("dflush_data", d, 64'd6);
        fbase = flush_cnt;
        @(posedge clock);
        #1;
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        @(negedge clock);
        chk("dflush_valid",  64'(bus.resp_valid),   64'd0);
        chk("dflush_idle",   64'(bus.req_ready),    64'd1);
        chk("dflush_nopuls", 64'(flush_cnt - fbase), 64'd0);

        // muler never answers
        stub_mute = 1'b1;
        fbase = flush_cnt;
        run_op(MUL_OP_MUL, 1'b0, 64'd11, 64'd13, 1'b0, d, e);
        chk("to_err",    64'(e),                 64'd1);
        chk("to_data",   d,                      64'd0);
        chk("to_pulses", 64'(flush_cnt - fbase), 64'd1);
        chk("to_cycles", 64'(lat_cnt),           64'd64);
        release_resp();

        // reset in the middle of WAIT
        issue_only(MUL_OP_MUL, 1'b0, 64'd5, 64'd5);
        repeat (3) @(posedge clock);
        #1;
        fbase = flush_cnt;
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_flush",     64'(bus.mul_flush),     64'd0);
        chk("mrst_in_valid",  64'(bus.mul_in_valid),  64'd0);
        chk("mrst_req_ready", 64'(bus.req_ready),     64'd1);
        chk("mrst_resp_data", bus.resp_data,          64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        stub_mute = 1'b0;
        repeat (2) @(negedge clock);
        chk("mrst_nopulse", 64'(flush_cnt - fbase), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Requester side of the multiplier handshake; sits in the EXU between the issue stage and the multi-cycle `muler` responder.
- Accepts RV64M multiply ops from upstream with a valid/ready handshake.
- Drives the `muler` request pins and captures its one-cycle result pulse.
- Selects hi/lo or sign-extends the word result, then holds it for downstream under valid/ready.
- Handles pipeline flush, including cancelling an in-flight multiply.

Parameters:
- WAIT_MAX, 63: cycles allowed in WAIT before timeout error; counter width is clog2(WAIT_MAX+1).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- req_valid  in  1  upstream op valid.
- req_ready  out  1  controller can accept an op.
- req_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- req_word  in  1  MULW; honoured only with req_op=MUL.
- req_src1  in  64  rs1, drives the multiplicand.
- req_src2  in  64  rs2, drives the multiplier.
- flush  in  1  cancel any pending op this cycle.
- mul_in_valid  out  1  request valid to muler.
- mul_flush  out  1  one-cycle cancel pulse to muler.
- mul_mulw  out  1  32-bit mode.
- mul_signed  out  2  11 = s×s, 10 = s×u, 00 = u×u.
- mul_multiplicand  out  64  operand to muler.
- mul_multiplier  out  64  operand to muler.
- mul_out_ready  in  1  muler can accept.
- mul_out_valid  in  1  muler result pulse; lasts one cycle only.
- mul_result_hi  in  64  high product; zero except during the pulse.
- mul_result_lo  in  64  low product; zero except during the pulse.
- resp_valid  out  1  result valid downstream.
- resp_ready  in  1  downstream accepts.
- resp_data  out  64  selected result.
- resp_err  out  1  timeout flag; qualified by resp_valid.

Behaviour:
- Reset values: state=IDLE.
  - req_ready=1.
  - mul_in_valid=0, mul_flush=0.
  - resp_valid=0, resp_err=0, resp_data=0.
  - Operand, mode and result registers all 0.
- States:
  - IDLE:
    - req_ready=1 when flush=0.
    - On req_valid&req_ready: register op, word flag and operands, then go to ISSUE.
  - ISSUE:
    - mul_in_valid=1, driven from registers.
    - At the edge where mul_out_ready=1, the handshake completes and the state goes to WAIT.
    - mul_in_valid is 0 the cycle after acceptance.
  - WAIT:
    - mul_in_valid=0; the wait counter increments every cycle.
    - On mul_out_valid: capture the selected result and go to DONE.
    - If the counter reaches WAIT_MAX without mul_out_valid: pulse mul_flush, set err=1, result=0, go to DONE.
  - DONE:
    - resp_valid=1; resp_data and resp_err stable.
    - Go to IDLE on resp_ready.
- Mode mapping:
  - MUL: mul_signed=11.
  - MULH: mul_signed=11.
  - MULHSU: mul_signed=10.
  - MULHU: mul_signed=00.
  - mul_mulw=req_word&(op==MUL).
- Result select:
  - MUL: lo.
  - MULH, MULHSU, MULHU: hi.
  - MULW: {{32{lo[31]}}, lo[31:0]}.
  - req_word with op≠MUL is treated as the 64-bit op.
- Latency: req accept to resp_valid = 1 (ISSUE) + muler latency + 1 (capture). Minimum 3 cycles.
- Flush:
  - From ISSUE or WAIT: mul_flush=1 for exactly one cycle, return to IDLE, no response.
  - From DONE: drop resp_valid next cycle and return to IDLE.
  - From IDLE: no effect.
- Simultaneous events:
  - flush & req_valid: req_ready=0 that cycle, so the op is not accepted.
  - flush & mul_out_valid in WAIT: flush wins and the result is discarded.
  - A mul_out_valid that arrives in any state other than WAIT is ignored.
- resp_valid held while resp_ready=0: data must not change.
- Reset asserted mid-operation: all state returns to reset values asynchronously, with no mul_flush pulse.

Optional Feature:
- Macro: MULCTL_RESULT_REUSE_EN.
- Defined:
  - Keep the last completed 128-bit product with its src1, src2 and mul_signed, plus a cache-valid bit.
  - Cache-valid is cleared only by reset. Flushed or timed-out ops never update the cache.
  - An accepted op with word=0 whose src1, src2 and mul_signed all match a valid entry goes IDLE→DONE with the cached hi/lo selected. Latency is 1 cycle and no muler request is made.
- Undefined: every op is issued to the muler.

Decomposition:
- Package mul_pkg holds:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU;
  - mul_signed constants SGN_SS=2'b11, SGN_SU=2'b10, SGN_UU=2'b00;
  - the state enum IDLE/ISSUE/WAIT/DONE.
- One combinational sub-module, mul_result_sel: inputs op, word, hi, lo; output the 64-bit result.

Test Plan:
- MUL src1=3, src2=0xFFFF_FFFF_FFFF_FFFE → resp_data=0xFFFF_FFFF_FFFF_FFFA; mul_signed=11; mul_in_valid high exactly until accept.
- MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF → resp_data=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- MULHSU src1=0xFFFF_FFFF_FFFF_FFFF, src2=0xFFFF_FFFF_FFFF_FFFF → resp_data=0xFFFF_FFFF_FFFF_FFFF; mul_signed=10.
- MULW src1=0x7FFF_FFFF, src2=2 → resp_data=0xFFFF_FFFF_FFFF_FFFE; mul_mulw=1.
- Flush 5 cycles into WAIT → one-cycle mul_flush, no resp_valid. A later stray mul_out_valid is ignored. The next MUL 4×5 returns 20.
- Hold resp_ready=0 for 6 cycles in DONE → resp_data stable, req_ready=0. Separately, a stub muler that never responds → resp_err=1 after WAIT_MAX=63 cycles.
